// File: rtl/bram_bus_arbiter_pkg.sv
// bram_bus_arbiter_pkg: owner-state encodings and counter sizing helper for the BRAM arbiter.
package bram_arb_pkg;
  typedef enum logic [1:0] {
    ARB_CPU   = 2'd0,
    ARB_DRAIN = 2'd1,
    ARB_DMA   = 2'd2
  } arb_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/bram_bus_arbiter_if.sv
// bram_bus_arbiter_if: CPU, DMA and BRAM bus signals; names are from the arbiter's point of view.
interface bram_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_Cpu_Req;
  logic              i_Cpu_We;
  logic [ADDR_W-1:0] i_Cpu_Addr;
  logic [DATA_W-1:0] i_Cpu_Wdata;
  logic              o_Cpu_Stall;
  logic              o_Cpu_Ready;
  logic [DATA_W-1:0] o_Cpu_Rdata;
  logic              i_Dma_Bus_Req;
  logic              o_Dma_Bus_Grant;
  logic              i_Dma_En;
  logic              i_Dma_We;
  logic [ADDR_W-1:0] i_Dma_Addr;
  logic [DATA_W-1:0] i_Dma_Wdata;
  logic [DATA_W-1:0] o_Dma_Rdata;
  logic              o_Bram_En;
  logic              o_Bram_We;
  logic [ADDR_W-1:0] o_Bram_Addr;
  logic [DATA_W-1:0] o_Bram_Wdata;
  logic [DATA_W-1:0] i_Bram_Rdata;
  modport slave (
    input  i_Cpu_Req, i_Cpu_We, i_Cpu_Addr, i_Cpu_Wdata,
    output o_Cpu_Stall, o_Cpu_Ready, o_Cpu_Rdata,
    input  i_Dma_Bus_Req, i_Dma_En, i_Dma_We, i_Dma_Addr, i_Dma_Wdata,
    output o_Dma_Bus_Grant, o_Dma_Rdata,
    output o_Bram_En, o_Bram_We, o_Bram_Addr, o_Bram_Wdata,
    input  i_Bram_Rdata
  );
  modport master (
    output i_Cpu_Req, i_Cpu_We, i_Cpu_Addr, i_Cpu_Wdata,
    input  o_Cpu_Stall, o_Cpu_Ready, o_Cpu_Rdata,
    output i_Dma_Bus_Req, i_Dma_En, i_Dma_We, i_Dma_Addr, i_Dma_Wdata,
    input  o_Dma_Bus_Grant, o_Dma_Rdata,
    input  o_Bram_En, o_Bram_We, o_Bram_Addr, o_Bram_Wdata,
    output i_Bram_Rdata
  );
endinterface

// File: rtl/bram_bus_arbiter.sv
// bram_bus_arbiter: shares one single-port BRAM between the CPU (default owner) and the UART DMA.
module bram_bus_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DMA_BURST = 16,
  parameter int CPU_SLOTS     = 4
) (
  input  logic                i_Clock,
  input  logic                i_Reset,
  bram_bus_arbiter_if.slave   bus,
  output logic [1:0]          o_State
);
  localparam int BW = clog2(MAX_DMA_BURST > 2 ? MAX_DMA_BURST : 2);
  localparam int GW = clog2(CPU_SLOTS + 1 > 2 ? CPU_SLOTS + 1 : 2);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_DMA_BURST == 0 ? 0 : MAX_DMA_BURST - 1);
  localparam logic [GW-1:0] GUARD_INIT = GW'(CPU_SLOTS);
  localparam logic          LIMITED    = MAX_DMA_BURST != 0;
  arb_state_t        r_state, w_next;
  logic              r_grant, w_grant_next;
  logic              r_ready;
  logic [BW-1:0]     r_burst, w_burst_next;
  logic [GW-1:0]     r_guard, w_guard_next;
  logic              w_guard_zero, w_stall, w_cpu_acc, w_dma_acc, w_at_limit, w_sel_dma;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  assign w_guard_zero = r_guard == '0;
  assign w_stall      = (r_state != ARB_CPU) | (bus.i_Dma_Bus_Req & w_guard_zero);
  assign w_cpu_acc    = (r_state == ARB_CPU) & bus.i_Cpu_Req & ~w_stall;
  assign w_dma_acc    = (r_state == ARB_DMA) & bus.i_Dma_En & r_grant;
  assign w_at_limit   = LIMITED & (r_burst == BURST_LAST);
  assign w_sel_dma    = r_state == ARB_DMA;
  always_comb begin
    w_next       = r_state;
    w_grant_next = r_grant;
    w_burst_next = r_burst;
    w_guard_next = r_guard;
    case (r_state)
      ARB_CPU: begin
        if (!w_guard_zero) w_guard_next = r_guard - GW'(1);
        else if (bus.i_Dma_Bus_Req) begin
          w_next       = ARB_DRAIN;
          w_burst_next = '0;
        end
      end
      ARB_DRAIN: begin
        w_next       = bus.i_Dma_Bus_Req ? ARB_DMA : ARB_CPU;
        w_grant_next = bus.i_Dma_Bus_Req;
      end
      ARB_DMA: begin
        if (!bus.i_Dma_Bus_Req) begin
          w_next       = ARB_CPU;
          w_grant_next = 1'b0;
        end else if (w_dma_acc & w_at_limit & bus.i_Cpu_Req) begin
          w_next       = ARB_CPU;
          w_grant_next = 1'b0;
          w_guard_next = GUARD_INIT;
        end else if (w_dma_acc & ~w_at_limit) w_burst_next = r_burst + BW'(1);
      end
      default: begin
        w_next       = ARB_CPU;
        w_grant_next = 1'b0;
      end
    endcase
  end
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_state <= ARB_CPU;
      r_grant <= 1'b0;
      r_ready <= 1'b0;
      r_burst <= '0;
      r_guard <= '0;
    end else begin
      r_state <= w_next;
      r_grant <= w_grant_next;
      r_ready <= w_cpu_acc;
      r_burst <= w_burst_next;
      r_guard <= w_guard_next;
    end
  end
  // Enable is gated by reset so the BRAM sees no strobe while reset is held.
  assign w_addr           = w_sel_dma ? bus.i_Dma_Addr : bus.i_Cpu_Addr;
  assign w_wdata          = w_sel_dma ? bus.i_Dma_Wdata : bus.i_Cpu_Wdata;
  assign bus.o_Bram_En    = i_Reset & (w_cpu_acc | w_dma_acc);
  assign bus.o_Bram_We    = bus.o_Bram_En & (w_sel_dma ? bus.i_Dma_We : bus.i_Cpu_We);
  assign bus.o_Bram_Addr  = w_addr;
  assign bus.o_Bram_Wdata = w_wdata;
  assign bus.o_Cpu_Stall  = w_stall;
  assign bus.o_Cpu_Ready  = r_ready;
  assign bus.o_Cpu_Rdata  = bus.i_Bram_Rdata;
  assign bus.o_Dma_Rdata  = bus.i_Bram_Rdata;
  assign bus.o_Dma_Bus_Grant = r_grant;
  assign o_State          = r_state;
endmodule

// File: tb/tb_bram_bus_arbiter.sv
// tb_bram_bus_arbiter: directed and randomized checks of the arbiter against an ownership model and a shadow memory.
module tb_bram_bus_arbiter;
  localparam int MAXB  = 16;
  localparam int SLOTS = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state;
  always #5 clk = ~clk;
  bram_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  bram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DMA_BURST(MAXB), .CPU_SLOTS(SLOTS)) dut (
    .i_Clock(clk), .i_Reset(rst_n), .bus(bus), .o_State(state)
  );
  logic [31:0] mem    [256];
  logic [31:0] shadow [256];
  always @(posedge clk)
    if (bus.o_Bram_En) begin
      if (bus.o_Bram_We) mem[bus.o_Bram_Addr[7:0]] <= bus.o_Bram_Wdata;
      else bus.i_Bram_Rdata <= mem[bus.o_Bram_Addr[7:0]];
    end
  int n_tests = 0, n_fail = 0;
  int m_own, m_slots, m_acc;
  bit m_grant, m_cpu_done, m_cpu_rd, m_dma_rd;
  logic [31:0] m_cpu_data, m_dma_data;
  logic [1:0]  s_state;
  logic        s_grant, s_stall, s_en, s_we, s_ready;
  logic [31:0] s_rdata;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_own = 0; m_slots = 0; m_acc = 0; m_grant = 0;
    m_cpu_done = 0; m_cpu_rd = 0; m_dma_rd = 0;
  endtask
  // One clock: compare outputs at the falling edge, then advance the model with the same inputs.
  task automatic cycle();
    bit e_stall, e_en, e_we, dma_side;
    logic [31:0] e_addr, e_wdata;
    @(negedge clk);
    dma_side = m_own == 2;
    e_stall  = m_own != 0 || (bus.i_Dma_Bus_Req && m_slots == 0);
    e_en     = m_own == 0 ? (bus.i_Cpu_Req && !e_stall) : (dma_side && bus.i_Dma_En && m_grant);
    e_we     = e_en && (dma_side ? bus.i_Dma_We : bus.i_Cpu_We);
    e_addr   = dma_side ? bus.i_Dma_Addr : bus.i_Cpu_Addr;
    e_wdata  = dma_side ? bus.i_Dma_Wdata : bus.i_Cpu_Wdata;
    chk("state", 32'(state), 32'(m_own));
    chk("grant", 32'(bus.o_Dma_Bus_Grant), 32'(m_grant));
    chk("stall", 32'(bus.o_Cpu_Stall), 32'(e_stall));
    chk("bram_en", 32'(bus.o_Bram_En), 32'(e_en));
    chk("bram_we", 32'(bus.o_Bram_We), 32'(e_we));
    chk("cpu_ready", 32'(bus.o_Cpu_Ready), 32'(m_cpu_done));
    if (m_cpu_done && m_cpu_rd) chk("cpu_rdata", bus.o_Cpu_Rdata, m_cpu_data);
    if (m_dma_rd) chk("dma_rdata", bus.o_Dma_Rdata, m_dma_data);
    if (e_en) chk("bram_addr", bus.o_Bram_Addr, e_addr);
    if (e_we) chk("bram_wdata", bus.o_Bram_Wdata, e_wdata);
    s_state = state; s_grant = bus.o_Dma_Bus_Grant; s_stall = bus.o_Cpu_Stall;
    s_en = bus.o_Bram_En; s_we = bus.o_Bram_We; s_ready = bus.o_Cpu_Ready; s_rdata = bus.o_Cpu_Rdata;
    m_cpu_done = m_own == 0 && e_en;
    m_cpu_rd   = m_cpu_done && !e_we;
    m_cpu_data = shadow[e_addr[7:0]];
    m_dma_rd   = dma_side && e_en && !e_we;
    m_dma_data = shadow[e_addr[7:0]];
    if (e_we) shadow[e_addr[7:0]] = e_wdata;
    if (m_own == 0) begin
      if (m_slots > 0) m_slots--;
      else if (bus.i_Dma_Bus_Req) begin m_own = 1; m_acc = 0; end
    end else if (m_own == 1) begin
      m_own   = bus.i_Dma_Bus_Req ? 2 : 0;
      m_grant = bus.i_Dma_Bus_Req;
    end else if (!bus.i_Dma_Bus_Req) begin
      m_own = 0; m_grant = 0;
    end else if (e_en && bus.i_Cpu_Req && m_acc + 1 >= MAXB) begin
      m_own = 0; m_grant = 0; m_slots = SLOTS;
    end else if (e_en) m_acc++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    int n, wr, served, gap;
    for (int i = 0; i < 256; i++) begin mem[i] = 0; shadow[i] = 0; end
    bus.i_Cpu_Req = 0; bus.i_Cpu_We = 0; bus.i_Cpu_Addr = 0; bus.i_Cpu_Wdata = 0;
    bus.i_Dma_Bus_Req = 0; bus.i_Dma_En = 0; bus.i_Dma_We = 0; bus.i_Dma_Addr = 0; bus.i_Dma_Wdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_grant", 32'(bus.o_Dma_Bus_Grant), 0);
    chk("rst_ready", 32'(bus.o_Cpu_Ready), 0);
    chk("rst_en", 32'(bus.o_Bram_En), 0);
    @(posedge clk); #1 rst_n = 1;
    bus.i_Cpu_Req = 1; bus.i_Cpu_We = 1; bus.i_Cpu_Addr = 32'h10; bus.i_Cpu_Wdata = 32'hDEADBEEF;
    cycle();
    bus.i_Cpu_We = 0;
    cycle();
    bus.i_Cpu_Req = 0;
    cycle();
    chk("rb_ready", 32'(s_ready), 1);
    chk("rb_data", s_rdata, 32'hDEADBEEF);
    bus.i_Cpu_Req = 1;
    cycle();
    bus.i_Dma_Bus_Req = 1;
    cycle();
    chk("drn_ready", 32'(s_ready), 1);
    chk("drn_data", s_rdata, 32'hDEADBEEF);
    chk("drn_stall", 32'(s_stall), 1);
    cycle();
    chk("drn_state", 32'(s_state), 1);
    cycle();
    chk("drn_grant", 32'(s_grant), 1);
    chk("drn_dma", 32'(s_state), 2);
    bus.i_Dma_Bus_Req = 0;
    repeat (2) cycle();
    bus.i_Cpu_Addr = 1; bus.i_Dma_Bus_Req = 1; bus.i_Dma_En = 1; bus.i_Dma_We = 1;
    wr = 0; n = 0;
    do begin
      bus.i_Dma_Addr = 32'h20 + 32'(n); bus.i_Dma_Wdata = $urandom;
      cycle();
      if (s_state == 2 && s_en && s_we) wr++;
      n++;
    end while (!(wr > 0 && !s_grant) && n < 40);
    chk("burst_writes", 32'(wr), 16);
    served = (s_state == 0 && !s_stall) ? 1 : 0;
    n = 0;
    do begin cycle(); if (!s_stall) served++; n++; end while (!s_stall && n < 20);
    chk("guard_slots", 32'(served), 4);
    gap = 0;
    do begin cycle(); gap++; end while (!s_grant && gap < 10);
    chk("regrant_gap", 32'(gap), 2);
    bus.i_Dma_Bus_Req = 0; bus.i_Dma_En = 0; bus.i_Cpu_Req = 0;
    repeat (2) cycle();
    bus.i_Dma_Bus_Req = 1;
    n = 0;
    do begin cycle(); n++; end while (!s_grant && n < 10);
    chk("grant_wait", 32'(s_grant), 1);
    bus.i_Dma_En = 1; wr = 0;
    for (int i = 0; i < 20; i++) begin
      bus.i_Dma_Addr = 32'h40 + 32'(i); bus.i_Dma_Wdata = $urandom;
      cycle();
      if (s_state == 2 && s_en && s_we) wr++;
    end
    chk("nolimit_writes", 32'(wr), 20);
    chk("nolimit_grant", 32'(s_grant), 1);
    bus.i_Cpu_Req = 1;
    #2 rst_n = 0;
    #1;
    chk("arst_grant", 32'(bus.o_Dma_Bus_Grant), 0);
    chk("arst_en", 32'(bus.o_Bram_En), 0);
    chk("arst_ready", 32'(bus.o_Cpu_Ready), 0);
    chk("arst_state", 32'(state), 0);
    bus.i_Cpu_Req = 0; bus.i_Dma_Bus_Req = 0; bus.i_Dma_En = 0;
    @(posedge clk); #1 rst_n = 1;
    model_reset();
    bus.i_Dma_Bus_Req = 1;
    cycle();
    chk("abort_stall", 32'(s_stall), 1);
    bus.i_Dma_Bus_Req = 0;
    cycle();
    chk("abort_drain", 32'(s_state), 1);
    cycle();
    chk("abort_state", 32'(s_state), 0);
    chk("abort_grant", 32'(s_grant), 0);
    chk("abort_stall0", 32'(s_stall), 0);
    for (int i = 0; i < 600; i++) begin
      if (!(bus.i_Cpu_Req && s_stall)) begin
        bus.i_Cpu_Req = $urandom_range(0, 3) != 0; bus.i_Cpu_We = 1'($urandom);
        bus.i_Cpu_Addr = $urandom_range(0, 15); bus.i_Cpu_Wdata = $urandom;
      end
      if ($urandom_range(0, 7) == 0) bus.i_Dma_Bus_Req = ~bus.i_Dma_Bus_Req;
      bus.i_Dma_En = $urandom_range(0, 3) != 0; bus.i_Dma_We = 1'($urandom);
      bus.i_Dma_Addr = $urandom_range(0, 15); bus.i_Dma_Wdata = $urandom;
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
